// File: rtl/win_sched_pkg.sv
`timescale 1ns/1ps
// Shared types and frame geometry for the window scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package win_sched_pkg;

    // Frame-level scheduler states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Image / window geometry of one frame
    localparam int IMG_ROWS    = 80;
    localparam int WIN_PER_ROW = 64;
    localparam int WIN_ROWS    = 65;
    localparam int WIN_DATA_W  = 32;

endpackage

// File: rtl/win_fifo.sv
`timescale 1ns/1ps
// Generic first-word-fall-through FIFO, WIDTH x DEPTH (DEPTH power of 2, >= 2).
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module win_fifo #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/window_sched.sv
`timescale 1ns/1ps
// Frame scheduler: runs one handler pass per frame, addresses image SRAM, queues windows for the correlator.
// Latency: mem_addr combinational from row/col; a captured window reaches win_* one cycle after hdl_receive.
// Backpressure: win_valid/win_receive pop; a window arriving at a full FIFO with no pop is dropped and sets ovf_err. Optional WIN_SCHED_PERF_EN adds perf counters.
module window_sched
    import win_sched_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int WORDS_PER_ROW = 20,
    parameter int FIFO_DEPTH    = 8,
    parameter int IDX_W         = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    frame_base,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 ovf_err,
    output logic                 hdl_en,
    input  logic                 hdl_ack,
    input  logic [6:0]           hdl_row,
    input  logic [6:0]           hdl_col,
    input  logic                 hdl_window_ready,
    input  logic [31:0]          hdl_window_data,
    input  logic                 hdl_done,
    output logic                 hdl_receive,
    output logic                 mem_rd,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 win_valid,
    output logic [31:0]          win_data,
    output logic [IDX_W-1:0]     win_idx,
    input  logic                 win_receive
`ifdef WIN_SCHED_PERF_EN
   ,output logic [31:0]          perf_stall_cyc,
    output logic [$clog2(FIFO_DEPTH):0] perf_max_occ
`endif
);
    localparam int ENT_W = IDX_W + WIN_DATA_W;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [IDX_W-1:0]    win_cnt_q, win_cnt_d;
    logic                ovf_q, ovf_d;

    logic                start_acc, push_req, fifo_push, fifo_pop, drop;
    logic                fifo_full, fifo_empty;
    logic [ENT_W-1:0]    fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] occ;
    logic [ADDR_W-1:0]   row_off, addr_sum;

    assign start_acc = (state_q == IDLE) && start;
    assign push_req  = ((state_q == START) || (state_q == RUN)) && hdl_window_ready;
    assign fifo_pop  = !fifo_empty && win_receive;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && fifo_full && !fifo_pop;

    win_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({win_cnt_q, hdl_window_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occ)
    );

    // Next state and per-state control outputs
    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        hdl_en     = 1'b0;
        mem_rd     = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = START;
            end
            START: begin
                hdl_en = 1'b1;
                if (hdl_ack) state_d = RUN;
            end
            RUN: begin
                mem_rd = 1'b1;
                if (hdl_done) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window sequence number and sticky overflow; dropped windows still consume a number
    always_comb begin
        win_cnt_d = win_cnt_q;
        ovf_d     = ovf_q;
        if (start_acc) begin
            win_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            if (push_req) win_cnt_d = win_cnt_q + IDX_ONE;
            if (drop)     ovf_d     = 1'b1;
        end
    end

    // State, frame base and window bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            win_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            ovf_q     <= ovf_d;
            if (start_acc) base_q <= frame_base;
        end
    end

    // SRAM address: base + row*WORDS_PER_ROW + col, wrapping at ADDR_W bits
    always_comb begin
        row_off  = ADDR_W'(hdl_row) * ADDR_W'(WORDS_PER_ROW);
        addr_sum = base_q + row_off + ADDR_W'(hdl_col);
        mem_addr = mem_rd ? addr_sum : '0;
    end

    assign hdl_receive = fifo_push;
    assign ovf_err     = ovf_q;
    assign win_valid   = !fifo_empty;
    // Head fields read as zero while the FIFO is empty
    assign win_data    = fifo_empty ? '0 : fifo_dout[WIN_DATA_W-1:0];
    assign win_idx     = fifo_empty ? '0 : fifo_dout[ENT_W-1:WIN_DATA_W];

`ifdef WIN_SCHED_PERF_EN
    logic [31:0]                 stall_q;
    logic [$clog2(FIFO_DEPTH):0] max_occ_q;

    // Stall cycles and peak occupancy, cleared on an accepted start, saturating
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_q   <= '0;
            max_occ_q <= '0;
        end else begin
            if (win_valid && !win_receive && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (occ > max_occ_q) max_occ_q <= occ;
        end
    end

    assign perf_stall_cyc = stall_q;
    assign perf_max_occ   = max_occ_q;
`else
    logic occ_unused;
    assign occ_unused = ^occ;
`endif

endmodule

// File: tb/tb_window_sched.sv
`timescale 1ns/1ps
// Self-checking bench for window_sched: directed frames plus randomized handler traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_window_sched;
    localparam int ADDR_W = 16;
    localparam int WPR    = 20;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 13;
    localparam int NWIN   = 4160;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] frame_base;
    logic              busy, frame_done, ovf_err, hdl_en;
    logic              hdl_ack;
    logic [6:0]        hdl_row, hdl_col;
    logic              hdl_window_ready;
    logic [31:0]       hdl_window_data;
    logic              hdl_done;
    logic              hdl_receive, mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              win_valid;
    logic [31:0]       win_data;
    logic [IDX_W-1:0]  win_idx;
    logic              win_receive;
`ifdef WIN_SCHED_PERF_EN
    logic [31:0]       perf_stall_cyc;
    logic [3:0]        perf_max_occ;
`endif

    window_sched #(
        .ADDR_W(ADDR_W), .WORDS_PER_ROW(WPR), .FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_base(frame_base),
        .busy(busy), .frame_done(frame_done), .ovf_err(ovf_err),
        .hdl_en(hdl_en), .hdl_ack(hdl_ack), .hdl_row(hdl_row), .hdl_col(hdl_col),
        .hdl_window_ready(hdl_window_ready), .hdl_window_data(hdl_window_data),
        .hdl_done(hdl_done), .hdl_receive(hdl_receive),
        .mem_rd(mem_rd), .mem_addr(mem_addr),
        .win_valid(win_valid), .win_data(win_data), .win_idx(win_idx),
        .win_receive(win_receive)
`ifdef WIN_SCHED_PERF_EN
       ,.perf_stall_cyc(perf_stall_cyc), .perf_max_occ(perf_max_occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: frame phase 0 idle,1 start,2 run,3 drain,4 done; window queue of {idx,data}
    int          phase;
    logic [44:0] mq[$];
    logic [15:0] m_base;
    logic [12:0] m_cnt;
    logic        m_ovf;
    int          fd_cnt;
    logic [12:0] popped[$];
    logic        obs_rcv, obs_en;
`ifdef WIN_SCHED_PERF_EN
    logic [31:0] m_stall;
    int          m_maxocc;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, then advance the model across the edge
    task automatic cyc();
        logic        pop_e, req_e, acc_e;
        logic [15:0] addr_e;
        logic [44:0] head_e;
        int          sz;
        #1;
        sz     = mq.size();
        pop_e  = (sz != 0) && win_receive;
        req_e  = ((phase == 1) || (phase == 2)) && hdl_window_ready;
        acc_e  = req_e && ((sz < DEPTH) || pop_e);
        addr_e = (phase == 2) ? 16'(int'(m_base) + int'(hdl_row) * WPR + int'(hdl_col)) : 16'h0;
        head_e = (sz != 0) ? mq[0] : 45'h0;
        chk("busy", busy, phase != 0);
        chk("hdl_en", hdl_en, phase == 1);
        chk("mem_rd", mem_rd, phase == 2);
        chk("mem_addr", mem_addr, addr_e);
        chk("frame_done", frame_done, phase == 4);
        chk("hdl_receive", hdl_receive, acc_e);
        chk("ovf_err", ovf_err, m_ovf);
        chk("win_valid", win_valid, sz != 0);
        chk("win_head", {win_idx, win_data}, head_e);
`ifdef WIN_SCHED_PERF_EN
        chk("perf_stall", perf_stall_cyc, m_stall);
        chk("perf_max_occ", perf_max_occ, m_maxocc);
`endif
        obs_rcv = hdl_receive;
        obs_en  = hdl_en;
        if (frame_done) fd_cnt++;
        if (pop_e) popped.push_back(win_idx);
        @(posedge clk);
        if (rst) begin
            phase = 0; mq.delete(); m_cnt = '0; m_ovf = 1'b0;
`ifdef WIN_SCHED_PERF_EN
            m_stall = '0; m_maxocc = 0;
`endif
        end else begin
`ifdef WIN_SCHED_PERF_EN
            if (phase == 0 && start) begin
                m_stall = '0; m_maxocc = 0;
            end else begin
                if (sz != 0 && !win_receive && m_stall != 32'hFFFF_FFFF) m_stall++;
                if (sz > m_maxocc) m_maxocc = sz;
            end
`endif
            if (pop_e) void'(mq.pop_front());
            if (acc_e) mq.push_back({m_cnt, hdl_window_data});
            if (req_e) begin
                if (!acc_e) m_ovf = 1'b1;
                m_cnt = m_cnt + 13'd1;
            end
            case (phase)
                0: if (start) begin phase = 1; m_base = frame_base; m_cnt = '0; m_ovf = 1'b0; end
                1: if (hdl_ack) phase = 2;
                2: if (hdl_done) phase = 3;
                3: if (sz == 0) phase = 4;
                default: phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic do_start(input logic [15:0] base);
        start = 1'b1; frame_base = base;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_ack();
        hdl_ack = 1'b1;
        cyc();
        hdl_ack = 1'b0;
    endtask

    task automatic rnd_win(input int ready_pct);
        hdl_window_ready = ($urandom_range(0, 99) < ready_pct);
        hdl_window_data  = $urandom;
        hdl_row          = 7'($urandom_range(0, 79));
        hdl_col          = 7'($urandom_range(0, 127));
    endtask

    // Let the frame drain with the consumer always ready, bounded
    task automatic wait_idle();
        hdl_window_ready = 1'b0; hdl_done = 1'b0; win_receive = 1'b1;
        for (int i = 0; i < 40 && phase != 0; i++) cyc();
        chk("drain_timeout_busy", busy, 1'b0);
    endtask

    task automatic end_frame();
        hdl_window_ready = 1'b0; hdl_done = 1'b1;
        cyc();
        hdl_done = 1'b0;
        wait_idle();
    endtask

    initial begin
        int en_cnt, n, bad, fd0, guard;
        rst = 1'b1; start = 1'b0; frame_base = '0; hdl_ack = 1'b0; hdl_row = '0; hdl_col = '0;
        hdl_window_ready = 1'b0; hdl_window_data = '0; hdl_done = 1'b0; win_receive = 1'b0;
        phase = 0; m_base = '0; m_cnt = '0; m_ovf = 1'b0; fd_cnt = 0; obs_rcv = 1'b0; obs_en = 1'b0;
`ifdef WIN_SCHED_PERF_EN
        m_stall = '0; m_maxocc = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_hdl_en", hdl_en, 0);
        chk("rst_hdl_receive", hdl_receive, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_data", win_data, 0);
        chk("rst_win_idx", win_idx, 0);
        rst = 1'b0;

        // Step 1: enable/ack handshake with ack in the third enable cycle, then address check
        do_start(16'h0100);
        en_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            hdl_ack = (i == 2);
            cyc();
            if (obs_en) en_cnt++;
        end
        hdl_ack = 1'b0;
        chk("hdl_en_cycles", en_cnt, 3);
        hdl_row = 7'd2; hdl_col = 7'd5;
        #1;
        chk("addr_row2_col5", mem_addr, 16'h012D);
        chk("busy_in_run", busy, 1);
        cyc();
        for (int i = 0; i < 20; i++) begin rnd_win(0); cyc(); end
        fd0 = fd_cnt;
        end_frame();
        chk("frame1_done_pulses", fd_cnt - fd0, 1);

        // Step 2: full frame with consumer always ready, done on the last window
        popped.delete();
        do_start(16'($urandom));
        do_ack();
        win_receive = 1'b1;
        n = 0; guard = 0;
        while (n < NWIN && guard < 20000) begin
            rnd_win(75);
            if (hdl_window_ready) n++;
            hdl_done = hdl_window_ready && (n == NWIN);
            cyc();
            guard++;
        end
        hdl_done = 1'b0;
        fd0 = fd_cnt;
        wait_idle();
        chk("frame2_done_pulses", fd_cnt - fd0, 1);
        chk("frame2_pop_count", popped.size(), NWIN);
        bad = 0;
        foreach (popped[i]) if (popped[i] != 13'(i)) bad++;
        chk("frame2_idx_order_bad", bad, 0);
        chk("frame2_ovf", ovf_err, 0);

        // Step 3: nine windows into an eight-deep FIFO with no consumer
        popped.delete();
        do_start(16'h2000);
        do_ack();
        win_receive = 1'b0;
        for (int i = 0; i < 9; i++) begin rnd_win(100); cyc(); end
        chk("ninth_window_receive", obs_rcv, 0);
        hdl_window_ready = 1'b0;
        chk("ovf_set", ovf_err, 1);
        chk("full_win_valid", win_valid, 1);
        end_frame();
        chk("ovf_sticky_after_frame", ovf_err, 1);
        chk("ovf_pop_count", popped.size(), 8);
        for (int i = 0; i < 8 && i < popped.size(); i++) chk("ovf_pop_idx", popped[i], i);

        // Step 4: push into a full FIFO while the head pops
        popped.delete();
        do_start(16'h3000);
        do_ack();
        win_receive = 1'b0;
        for (int i = 0; i < 8; i++) begin rnd_win(100); cyc(); end
        rnd_win(100); win_receive = 1'b1;
        cyc();
        chk("full_pop_push_receive", obs_rcv, 1);
        hdl_window_ready = 1'b0; win_receive = 1'b0;
        chk("full_pop_push_ovf", ovf_err, 0);
        end_frame();
        chk("full_pop_push_total", popped.size(), 9);

        // Step 5: reset during RUN with five windows queued, then a fresh frame
        do_start(16'h4000);
        do_ack();
        win_receive = 1'b0;
        for (int i = 0; i < 5; i++) begin rnd_win(100); cyc(); end
        hdl_window_ready = 1'b0;
        fd0 = fd_cnt;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_win_valid", win_valid, 0);
        chk("midrst_hdl_en", hdl_en, 0);
        repeat (5) cyc();
        chk("midrst_no_done", fd_cnt - fd0, 0);
        do_start(16'($urandom));
        do_ack();
        for (int i = 0; i < 200; i++) begin
            rnd_win(60);
            win_receive = ($urandom_range(0, 1) == 1);
            cyc();
        end
        end_frame();
        chk("after_rst_done_pulses", fd_cnt - fd0, 1);

`ifdef WIN_SCHED_PERF_EN
        // Step 6: ten stalled cycles with a valid head
        do_start(16'h5000);
        do_ack();
        win_receive = 1'b0;
        rnd_win(100); cyc();
        hdl_window_ready = 1'b0;
        repeat (10) cyc();
        chk("perf_stall_10", perf_stall_cyc, 10);
        end_frame();
`endif

        // Random frame with a slow consumer, exercising overflow and wrapping addresses
        do_start(16'hFF00 | 16'($urandom_range(0, 255)));
        do_ack();
        for (int i = 0; i < 300; i++) begin
            rnd_win(50);
            win_receive = ($urandom_range(0, 2) == 0);
            cyc();
        end
        fd0 = fd_cnt;
        end_frame();
        chk("rand_done_pulses", fd_cnt - fd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
